// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// In-order queue of branch predictions captured at fetch from the blt lookup.
// Execute always resolves the oldest outstanding branch. The block compares the
// actual outcome with the stored prediction and drives the blt update port. On
// a mispredict it raises flush with the corrected fetch PC.
//
// Parameters
//   ADDR_WIDTH  PC / target width
//   DEPTH       maximum number of outstanding unresolved branches (power of two)
//   DEPTH_LOG2  log2(DEPTH)
//   PC_INC      fall-through increment added to the branch PC
//
// Ports
//   clk               in   clock, rising edge
//   reset             in   synchronous, active-high reset
//   push              in   fetch issued a branch; enqueue this cycle
//   push_pc           in   branch PC
//   push_pred_taken   in   blt read_valid at fetch
//   push_pred_target  in   blt read_val at fetch (ignored when not predicted taken)
//   resolve           in   execute resolved the oldest branch
//   resolve_taken     in   actual direction
//   resolve_target    in   actual taken target
//   full              out  count == DEPTH (combinational)
//   empty             out  count == 0 (combinational)
//   count             out  occupied entries
//   blt_write         out  registered one-cycle pulse -> blt write
//   blt_write_key     out  resolved entry PC -> blt write_key
//   blt_write_val     out  resolve_target -> blt write_val
//   blt_hit           out  resolve_taken -> blt hit
//   flush             out  registered one-cycle pulse on mispredict
//   flush_pc          out  corrected next fetch PC, valid while flush=1
//   mispredict_count  out  saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned PC_INC     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  push_pred_taken,
    input  logic [ADDR_WIDTH-1:0] push_pred_target,
    input  logic                  resolve,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  blt_write,
    output logic [ADDR_WIDTH-1:0] blt_write_key,
    output logic [ADDR_WIDTH-1:0] blt_write_val,
    output logic                  blt_hit,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [15:0]           mispredict_count
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_INC_C  = ADDR_WIDTH'(PC_INC);
    localparam logic [15:0]           MC_MAX_C  = 16'hFFFF;

    // ---------------------------------------------------------------
    // Entry storage (contents are don't-care after reset)
    // ---------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_mem_q     [DEPTH];
    logic                  taken_mem_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem_q [DEPTH];

    // Queue control state
    logic [DEPTH_LOG2-1:0] head_q,  head_d;
    logic [DEPTH_LOG2-1:0] tail_q,  tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // Registered output state
    logic                  blt_write_q,  blt_write_d;
    logic [ADDR_WIDTH-1:0] blt_key_q,    blt_key_d;
    logic [ADDR_WIDTH-1:0] blt_val_q,    blt_val_d;
    logic                  blt_hit_q,    blt_hit_d;
    logic                  flush_q,      flush_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q,   flush_pc_d;
    logic [15:0]           mis_cnt_q,    mis_cnt_d;

    // Combinational decode
    logic                  full_s;
    logic                  empty_s;
    logic                  eff_resolve_s;
    logic                  eff_push_s;
    logic                  mispredict_s;
    logic [ADDR_WIDTH-1:0] head_pc_s;
    logic                  head_taken_s;
    logic [ADDR_WIDTH-1:0] head_target_s;

    // Occupancy flags and head-entry read
    always_comb begin
        full_s        = (count_q == DEPTH_C);
        empty_s       = (count_q == (DEPTH_LOG2+1)'(0));
        head_pc_s     = pc_mem_q[head_q];
        head_taken_s  = taken_mem_q[head_q];
        head_target_s = target_mem_q[head_q];
    end

    // Resolve / mispredict / push qualification
    always_comb begin
        eff_resolve_s = resolve && !empty_s;
        mispredict_s  = 1'b0;
        if (eff_resolve_s) begin
            // The predicted target only matters when the blt predicted taken.
            mispredict_s = (resolve_taken != head_taken_s) ||
                           (resolve_taken && head_taken_s &&
                            (resolve_target != head_target_s));
        end else begin
            mispredict_s = 1'b0;
        end
        // A pop in the same cycle frees a slot, so a full queue can still accept.
        eff_push_s = push && (!full_s || eff_resolve_s) && !mispredict_s;
    end

    // Next-state for pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict_s) begin
            // Everything younger than the mispredicted branch is wrong-path.
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = (DEPTH_LOG2+1)'(0);
        end else begin
            if (eff_resolve_s) begin
                head_d = head_q + DEPTH_LOG2'(1);
            end else begin
                head_d = head_q;
            end
            if (eff_push_s) begin
                tail_d = tail_q + DEPTH_LOG2'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({eff_push_s, eff_resolve_s})
                2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
                2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for the blt update port, flush and mispredict counter
    always_comb begin
        blt_write_d = eff_resolve_s;
        blt_key_d   = blt_key_q;
        blt_val_d   = blt_val_q;
        blt_hit_d   = blt_hit_q;
        flush_d     = mispredict_s;
        flush_pc_d  = flush_pc_q;
        mis_cnt_d   = mis_cnt_q;
        if (eff_resolve_s) begin
            // Every resolve trains the blt, correct or not.
            blt_key_d = head_pc_s;
            blt_val_d = resolve_target;
            blt_hit_d = resolve_taken;
        end else begin
            blt_key_d = blt_key_q;
            blt_val_d = blt_val_q;
            blt_hit_d = blt_hit_q;
        end
        if (mispredict_s) begin
            if (resolve_taken) begin
                flush_pc_d = resolve_target;
            end else begin
                flush_pc_d = head_pc_s + PC_INC_C;
            end
            if (mis_cnt_q != MC_MAX_C) begin
                mis_cnt_d = mis_cnt_q + 16'd1;
            end else begin
                mis_cnt_d = mis_cnt_q;
            end
        end else begin
            flush_pc_d = flush_pc_q;
            mis_cnt_d  = mis_cnt_q;
        end
    end

    // Entry write on an accepted push
    always_ff @(posedge clk) begin
        if (!reset && eff_push_s) begin
            pc_mem_q[tail_q]     <= push_pc;
            taken_mem_q[tail_q]  <= push_pred_taken;
            target_mem_q[tail_q] <= push_pred_target;
        end
    end

    // Control and output state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= DEPTH_LOG2'(0);
            tail_q      <= DEPTH_LOG2'(0);
            count_q     <= (DEPTH_LOG2+1)'(0);
            blt_write_q <= 1'b0;
            blt_key_q   <= ADDR_WIDTH'(0);
            blt_val_q   <= ADDR_WIDTH'(0);
            blt_hit_q   <= 1'b0;
            flush_q     <= 1'b0;
            flush_pc_q  <= ADDR_WIDTH'(0);
            mis_cnt_q   <= 16'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            blt_write_q <= blt_write_d;
            blt_key_q   <= blt_key_d;
            blt_val_q   <= blt_val_d;
            blt_hit_q   <= blt_hit_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    assign full             = full_s;
    assign empty            = empty_s;
    assign count            = count_q;
    assign blt_write        = blt_write_q;
    assign blt_write_key    = blt_key_q;
    assign blt_write_val    = blt_val_q;
    assign blt_hit          = blt_hit_q;
    assign flush            = flush_q;
    assign flush_pc         = flush_pc_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        resolve;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        blt_write;
    logic [31:0] blt_write_key;
    logic [31:0] blt_write_val;
    logic        blt_hit;
    logic        flush;
    logic [31:0] flush_pc;
    logic [15:0] mispredict_count;

    branch_resolve_queue dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .resolve          (resolve),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .blt_write        (blt_write),
        .blt_write_key    (blt_write_key),
        .blt_write_val    (blt_write_val),
        .blt_hit          (blt_hit),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of outstanding predictions.
    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        m_write;
    logic [31:0] m_key;
    logic [31:0] m_val;
    logic        m_hit;
    logic        m_flush;
    logic [31:0] m_fpc;
    int          m_mc;

    int checks = 0;
    int errors = 0;

    task automatic model_clear();
        mq.delete();
        m_write = 1'b0;
        m_flush = 1'b0;
        m_mc    = 0;
    endtask

    task automatic model_step(input logic p, input logic [31:0] ppc, input logic pt,
                              input logic [31:0] ptg, input logic r, input logic rt,
                              input logic [31:0] rtg);
        bit   er;
        bit   mis;
        ent_t e;
        er  = r && (mq.size() > 0);
        mis = 1'b0;
        m_write = 1'b0;
        m_flush = 1'b0;
        if (er) begin
            e   = mq[0];
            mis = (rt != e.pt) || (rt && e.pt && (rtg != e.tgt));
            m_write = 1'b1;
            m_key   = e.pc;
            m_val   = rtg;
            m_hit   = rt;
            if (mis) begin
                m_flush = 1'b1;
                m_fpc   = rt ? rtg : (e.pc + 32'd1);
                if (m_mc < 65535) m_mc = m_mc + 1;
                mq.delete();
            end else begin
                void'(mq.pop_front());
            end
        end
        if (p && ((mq.size() < 8) || er) && !mis) begin
            e.pc  = ppc;
            e.pt  = pt;
            e.tgt = ptg;
            mq.push_back(e);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, return #1 after the edge.
    task automatic cycle(input logic p, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic r, input logic rt,
                         input logic [31:0] rtg);
        push = p; push_pc = ppc; push_pred_taken = pt; push_pred_target = ptg;
        resolve = r; resolve_taken = rt; resolve_target = rtg;
        @(posedge clk);
        model_step(p, ppc, pt, ptg, r, rt, rtg);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push = 1'b0; resolve = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (blt_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", blt_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (mispredict_count !== 16'd0) begin errors++; $display("FAIL reset_mc got=%0d exp=0", mispredict_count); end
    endtask

    task automatic test_correct_predict();
        cycle(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        checks++; if (blt_write !== 1'b1) begin errors++; $display("FAIL correct_write got=%b exp=1", blt_write); end
        checks++; if (blt_write_key !== 32'h10) begin errors++; $display("FAIL correct_key got=%h exp=10", blt_write_key); end
        checks++; if (blt_write_val !== 32'h40) begin errors++; $display("FAIL correct_val got=%h exp=40", blt_write_val); end
        checks++; if (blt_hit !== 1'b1) begin errors++; $display("FAIL correct_hit got=%b exp=1", blt_hit); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_flush got=%b exp=0", flush); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL correct_empty got=%b exp=1", empty); end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (blt_write !== 1'b0) begin errors++; $display("FAIL correct_write_drop got=%b exp=0", blt_write); end
    endtask

    task automatic test_mispredict_taken();
        cycle(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mt_flush got=%b exp=1", flush); end
        checks++; if (flush_pc !== 32'h80) begin errors++; $display("FAIL mt_flush_pc got=%h exp=80", flush_pc); end
        checks++; if (blt_hit !== 1'b1) begin errors++; $display("FAIL mt_hit got=%b exp=1", blt_hit); end
        checks++; if (mispredict_count !== 16'd1) begin errors++; $display("FAIL mt_mc got=%0d exp=1", mispredict_count); end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mt_flush_drop got=%b exp=0", flush); end
    endtask

    task automatic test_mispredict_not_taken();
        cycle(1'b1, 32'h30, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h34 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL mn_count_pre got=%0d exp=4", count); end
        // A push in the mispredict cycle must be discarded.
        cycle(1'b1, 32'h99, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mn_flush got=%b exp=1", flush); end
        checks++; if (flush_pc !== 32'h31) begin errors++; $display("FAIL mn_flush_pc got=%h exp=31", flush_pc); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mn_count got=%0d exp=0", count); end
        checks++; if (blt_hit !== 1'b0) begin errors++; $display("FAIL mn_hit got=%b exp=0", blt_hit); end
        checks++; if (mispredict_count !== 16'd2) begin errors++; $display("FAIL mn_mc got=%0d exp=2", mispredict_count); end
        // Push in the flush cycle is accepted normally.
        cycle(1'b1, 32'h31, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL mn_post_push got=%0d exp=1", count); end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (blt_write_key !== 32'h31 || flush !== 1'b0) begin
            errors++; $display("FAIL mn_post_resolve key=%h flush=%b exp key=31 flush=0", blt_write_key, flush);
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_key;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL full_set full=%b count=%0d exp 1/8", full, count); end
        cycle(1'b1, 32'h1FF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_drop count=%0d exp=8", count); end
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 32'h200 + 32'(k), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            exp_key = (k < 8) ? (32'h100 + 32'(k)) : (32'h200 + 32'(k - 8));
            checks++; if (blt_write_key !== exp_key || blt_write !== 1'b1) begin
                errors++; $display("FAIL wrap_key[%0d] got=%h wr=%b exp=%h", k, blt_write_key, blt_write, exp_key);
            end
            checks++; if (count !== 4'd8 || flush !== 1'b0) begin
                errors++; $display("FAIL wrap_count[%0d] got=%0d flush=%b exp=8", k, count, flush);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            exp_key = 32'h200 + 32'(12 + k);
            checks++; if (blt_write_key !== exp_key) begin errors++; $display("FAIL drain_key[%0d] got=%h exp=%h", k, blt_write_key, exp_key); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_empty_resolve();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h77);
        checks++; if (blt_write !== 1'b0) begin errors++; $display("FAIL er_write got=%b exp=0", blt_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL er_flush got=%b exp=0", flush); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL er_count got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL rm_pre got=%0d exp=5", count); end
        reset = 1'b1; push = 1'b1; resolve = 1'b1; resolve_taken = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0; push = 1'b0; resolve = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rm_state count=%0d empty=%b exp 0/1", count, empty); end
        checks++; if (blt_write !== 1'b0 || flush !== 1'b0 || mispredict_count !== 16'd0) begin
            errors++; $display("FAIL rm_outputs wr=%b fl=%b mc=%0d exp 0/0/0", blt_write, flush, mispredict_count);
        end
    endtask

    task automatic test_random();
        logic        p, pt, r, rt;
        logic [31:0] ppc, ptg, rtg;
        for (int n = 0; n < 400; n++) begin
            p   = ($urandom_range(0, 99) < 60);
            ppc = 32'($urandom);
            pt  = 1'($urandom_range(0, 1));
            ptg = 32'($urandom_range(0, 3)) << 4;
            r   = ($urandom_range(0, 99) < 45);
            rt  = 1'($urandom_range(0, 1));
            rtg = 32'($urandom_range(0, 3)) << 4;
            if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
                rt  = mq[0].pt;
                rtg = mq[0].pt ? mq[0].tgt : rtg;
            end
            cycle(p, ppc, pt, ptg, r, rt, rtg);
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, count, mq.size()); end
            checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == 8)) begin
                errors++; $display("FAIL rnd_flags[%0d] empty=%b full=%b size=%0d", n, empty, full, mq.size());
            end
            checks++; if (blt_write !== m_write) begin errors++; $display("FAIL rnd_write[%0d] got=%b exp=%b", n, blt_write, m_write); end
            checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", n, flush, m_flush); end
            checks++; if (mispredict_count !== 16'(m_mc)) begin errors++; $display("FAIL rnd_mc[%0d] got=%0d exp=%0d", n, mispredict_count, m_mc); end
            if (m_write) begin
                checks++; if (blt_write_key !== m_key || blt_write_val !== m_val || blt_hit !== m_hit) begin
                    errors++; $display("FAIL rnd_blt[%0d] key=%h val=%h hit=%b exp %h %h %b", n, blt_write_key, blt_write_val, blt_hit, m_key, m_val, m_hit);
                end
            end
            if (m_flush) begin
                checks++; if (flush_pc !== m_fpc) begin errors++; $display("FAIL rnd_fpc[%0d] got=%h exp=%h", n, flush_pc, m_fpc); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0; push_pc = 32'h0; push_pred_taken = 1'b0; push_pred_target = 32'h0;
        resolve = 1'b0; resolve_taken = 1'b0; resolve_target = 32'h0;
        model_clear();
        #2;
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_wrap();
        test_empty_resolve();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
